// File: rtl/dm_copy_engine.sv
// Block-copy initiator for the single-ported data memory: one read then one write per word.
// Optional running checksum of copied words when DM_COPY_CHECKSUM_EN is defined.
module dm_copy_engine #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int LW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] dm_addr,
    output logic          dm_re,
    output logic          dm_we,
    output logic [DW-1:0] dm_wrt_data,
    input  logic [DW-1:0] dm_rd_data
`ifdef DM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [AW-1:0] addr_d;
    logic          re_d, we_d, done_d;
    logic [DW-1:0] wdata_d;
`ifdef DM_COPY_CHECKSUM_EN
    logic [DW-1:0] sum_d;
`endif

    assign busy = (state_q != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // updates from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            dm_addr     <= '0;
            dm_re       <= 1'b0;
            dm_we       <= 1'b0;
            dm_wrt_data <= '0;
            done        <= 1'b0;
`ifdef DM_COPY_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            dm_addr     <= addr_d;
            dm_re       <= re_d;
            dm_we       <= we_d;
            dm_wrt_data <= wdata_d;
            done        <= done_d;
`ifdef DM_COPY_CHECKSUM_EN
            checksum    <= sum_d;
`endif
        end
    end

    // NOTE: every variable gets its hold/idle default first, so no branch of the
    // case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        addr_d  = dm_addr;
        re_d    = 1'b0;
        we_d    = 1'b0;
        wdata_d = dm_wrt_data;
        done_d  = 1'b0;
`ifdef DM_COPY_CHECKSUM_EN
        sum_d   = checksum;
`endif

        case (state_q)
            IDLE: begin
                // abort is deliberately ignored here; start always wins in IDLE.
                if (start) begin
`ifdef DM_COPY_CHECKSUM_EN
                    sum_d = '0;
`endif
                    if (len != '0) begin
                        state_d = READ;
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        rem_d   = len;
                        addr_d  = src_addr;
                        re_d    = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            READ: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = WRITE;
                    wdata_d = dm_rd_data;
                    addr_d  = dst_q;
                    we_d    = 1'b1;
                    src_d   = src_q + AW'(1);
`ifdef DM_COPY_CHECKSUM_EN
                    sum_d   = checksum + dm_rd_data;
`endif
                end
            end

            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    dst_d = dst_q + AW'(1);
                    rem_d = rem_q - LW'(1);
                    if (rem_q > LW'(1)) begin
                        state_d = READ;
                        addr_d  = src_q;
                        re_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Self-checking bench for dm_copy_engine: behavioural 64K-word memory, access log and a
// plain forward-copy reference model. Define DM_COPY_CHECKSUM_EN to also check checksum.
module tb_dm_copy_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [13:0] len;
    logic        busy;
    logic        done;
    logic [15:0] dm_addr;
    logic        dm_re;
    logic        dm_we;
    logic [15:0] dm_wrt_data;
    logic [15:0] dm_rd_data;
`ifdef DM_COPY_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    dm_copy_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .dm_addr     (dm_addr),
        .dm_re       (dm_re),
        .dm_we       (dm_we),
        .dm_wrt_data (dm_wrt_data),
        .dm_rd_data  (dm_rd_data)
`ifdef DM_COPY_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] ref_sum;
    acc_t        log_q[$];
    int          overlap_cnt;
    int          idle_acc_cnt;
    int          busy_cycles;
    int          done_cnt;
    logic        pk_we;
    logic [15:0] pk_addr;
    logic [15:0] pk_data;
    int          total;
    int          bad;

    // Memory model: the only process that writes mem or the access log.
    initial begin
        acc_t e;
        overlap_cnt  = 0;
        idle_acc_cnt = 0;
        busy_cycles  = 0;
        done_cnt     = 0;
        dm_rd_data   = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        forever begin
            @(negedge clk);
            if (pk_we) mem[pk_addr] = pk_data;
            if (rst_n) begin
                if (dm_re && dm_we) overlap_cnt++;
                if (!busy && (dm_re || dm_we)) idle_acc_cnt++;
                if (busy) busy_cycles++;
                if (done) done_cnt++;
                if (dm_we) begin
                    mem[dm_addr] = dm_wrt_data;
                    e.wr = 1'b1; e.addr = dm_addr; e.data = dm_wrt_data;
                    log_q.push_back(e);
                end
                if (dm_re) begin
                    dm_rd_data = mem[dm_addr];
                    e.wr = 1'b0; e.addr = dm_addr; e.data = dm_rd_data;
                    log_q.push_back(e);
                end
            end
        end
    end

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        pk_addr = a;
        pk_data = v;
        pk_we   = 1'b1;
        @(negedge clk);
        #1 pk_we = 1'b0;
        ref_mem[a] = v;
    endtask

    // Forward word-by-word copy on the reference memory; returns the number of log
    // entries (from base) that disagree with the expected read/write sequence.
    function automatic int log_check(input logic [15:0] s, input logic [15:0] d,
                                     input int n, input int base);
        int          errs;
        logic [15:0] sa, da, v;
        errs = 0;
        for (int k = 0; k < n; k++) begin
            sa = s + 16'(k);
            da = d + 16'(k);
            v  = ref_mem[sa];
            ref_sum = ref_sum + v;
            ref_mem[da] = v;
            if (base + 2 * k + 1 < log_q.size()) begin
                if (log_q[base + 2 * k].wr !== 1'b0 || log_q[base + 2 * k].addr !== sa) errs++;
                if (log_q[base + 2 * k + 1].wr !== 1'b1 || log_q[base + 2 * k + 1].addr !== da ||
                    log_q[base + 2 * k + 1].data !== v) errs++;
            end else begin
                errs++;
            end
        end
        if (log_q.size() != base + 2 * n) errs++;
        return errs;
    endfunction

    function automatic int mem_errors();
        int errs;
        errs = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) errs++;
        return errs;
    endfunction

    task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [13:0] n);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one complete copy from idle and checks timing, pulses, log, memory and checksum.
    task automatic run_copy(input string name, input logic [15:0] s, input logic [15:0] d,
                            input int n);
        int base, b0, d0, cyc, errs;
        base    = log_q.size();
        b0      = busy_cycles;
        d0      = done_cnt;
        ref_sum = '0;
        launch(s, d, 14'(n));
        cyc = 0;
        while (!done && cyc < 2 * n + 8) begin
            @(posedge clk);
            #1 cyc++;
        end
        total++;
        if (!done || cyc != 2 * n) begin
            bad++;
            $display("FAIL %s done_latency: got cycles=%0d done=%b, expected cycles=%0d done=1",
                     name, cyc, done, 2 * n);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_at_done: got %b, expected 0", name, busy);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_width: got done=%b one cycle later, expected 0", name, done);
        end
        total++;
        if (busy_cycles - b0 != 2 * n) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cycles - b0, 2 * n);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt - d0);
        end
        errs = log_check(s, d, n, base);
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s access_sequence: got %0d bad entries (log size %0d), expected 0",
                     name, errs, log_q.size() - base);
        end
        errs = mem_errors();
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s memory_image: got %0d differing words, expected 0", name, errs);
        end
`ifdef DM_COPY_CHECKSUM_EN
        total++;
        if (checksum !== ref_sum) begin
            bad++;
            $display("FAIL %s checksum: got %h, expected %h", name, checksum, ref_sum);
        end
`endif
    endtask

    task automatic test_reset();
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        pk_we    = 1'b0;
        pk_addr  = '0;
        pk_data  = '0;
        rst_n    = 1'b0;
        #12;
        total++;
        if ({busy, done, dm_re, dm_we} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got busy/done/re/we=%b, expected 0000",
                     {busy, done, dm_re, dm_we});
        end
        total++;
        if (dm_addr !== 16'h0 || dm_wrt_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_bus: got addr=%h wdata=%h, expected 0000 0000", dm_addr, dm_wrt_data);
        end
`ifdef DM_COPY_CHECKSUM_EN
        total++;
        if (checksum !== 16'h0) begin
            bad++;
            $display("FAIL reset_checksum: got %h, expected 0000", checksum);
        end
`endif
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_copy();
        poke(16'h0100, 16'h1111);
        poke(16'h0101, 16'h2222);
        poke(16'h0102, 16'h3333);
        poke(16'h0103, 16'h4444);
        @(posedge clk);
        #1;
        run_copy("basic", 16'h0100, 16'h0200, 4);
        total++;
        if (ref_sum !== 16'hAAAA || mem[16'h0203] !== 16'h4444) begin
            bad++;
            $display("FAIL basic_content: got sum=%h mem[0203]=%h, expected AAAA 4444",
                     ref_sum, mem[16'h0203]);
        end
    endtask

    task automatic test_zero_len();
        run_copy("zero_len", 16'h0300, 16'h0400, 0);
    endtask

    task automatic test_wrap();
        run_copy("wrap", 16'hFFFE, 16'h0010, 3);
    endtask

    task automatic test_overlap();
        poke(16'h0020, 16'hBEEF);
        @(posedge clk);
        #1;
        run_copy("overlap", 16'h0020, 16'h0021, 3);
        total++;
        if (mem[16'h0021] !== 16'hBEEF || mem[16'h0022] !== 16'hBEEF || mem[16'h0023] !== 16'hBEEF) begin
            bad++;
            $display("FAIL overlap_replicate: got %h %h %h, expected BEEF BEEF BEEF",
                     mem[16'h0021], mem[16'h0022], mem[16'h0023]);
        end
    endtask

    task automatic test_abort();
        int base, d0, errs;
        logic busy_before;
        base    = log_q.size();
        d0      = done_cnt;
        ref_sum = '0;
        busy_before = 1'b0;
        launch(16'h0500, 16'h0600, 14'd8);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                src_addr = 16'h0700;
                dst_addr = 16'h0800;
                len      = 14'd2;
                start    = 1'b1;
            end
            if (c == 3) start = 1'b0;
            if (c == 5) begin
                busy_before = busy;
                abort = 1'b1;
            end
            if (c == 6) abort = 1'b0;
        end
        total++;
        if (busy_before !== 1'b1 || busy !== 1'b0 || dm_re !== 1'b0 || dm_we !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got busy before/after=%b/%b re=%b we=%b, expected 1/0 0 0",
                     busy_before, busy, dm_re, dm_we);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done_cnt - d0 != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: got done pulses=%0d busy=%b, expected 0 0", done_cnt - d0, busy);
        end
        errs = log_check(16'h0500, 16'h0600, 3, base);
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL abort_words: got %0d bad entries (log size %0d), expected 3 words only",
                     errs, log_q.size() - base);
        end
        total++;
        if (mem_errors() != 0) begin
            bad++;
            $display("FAIL abort_memory: got %0d differing words, expected 0", mem_errors());
        end
    endtask

    task automatic test_reset_mid_write();
        int base;
        base = log_q.size();
        launch(16'h0900, 16'h0A00, 14'd4);
        @(posedge clk);
        #3;
        total++;
        if (dm_we !== 1'b1) begin
            bad++;
            $display("FAIL rst_precond_write: got we=%b, expected 1", dm_we);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, dm_re, dm_we} !== 4'b0000 || dm_addr !== 16'h0 || dm_wrt_data !== 16'h0) begin
            bad++;
            $display("FAIL rst_async: got busy/done/re/we=%b addr=%h wdata=%h, expected 0000 0000 0000",
                     {busy, done, dm_re, dm_we}, dm_addr, dm_wrt_data);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        total++;
        if (log_q.size() != base + 1 || mem_errors() != 0) begin
            bad++;
            $display("FAIL rst_no_write: got log entries=%0d memory diffs=%0d, expected 1 0",
                     log_q.size() - base, mem_errors());
        end
        @(posedge clk);
        #1;
        run_copy("after_reset", 16'h0900, 16'h0A00, 4);
    endtask

    task automatic test_random();
        logic [15:0] s, d;
        int          n;
        for (int i = 0; i < 6; i++) begin
            s = 16'($urandom);
            d = (i % 2 == 0) ? 16'($urandom) : s + 16'($urandom_range(1, 4));
            n = $urandom_range(1, 24);
            run_copy($sformatf("random%0d", i), s, d, n);
        end
    endtask

    task automatic test_invariants();
        total++;
        if (overlap_cnt != 0) begin
            bad++;
            $display("FAIL re_we_overlap: got %0d cycles, expected 0", overlap_cnt);
        end
        total++;
        if (idle_acc_cnt != 0) begin
            bad++;
            $display("FAIL idle_access: got %0d cycles, expected 0", idle_acc_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_wrap();
        test_overlap();
        test_abort();
        test_reset_mid_write();
        test_random();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_copy_engine.md
Name: dm_copy_engine

Overview:
- Bus initiator that drives the single-ported 8K×16 data memory interface (addr/re/we/wrt_data/rd_data) to copy a block of words from a source region to a destination region.
- Sits beside the CPU on the data-memory port. The top level muxes the port to this engine while `busy` is high.
- Honours the memory's rules: reads and writes on the falling clock edge, and never a read and a write in the same cycle. Each word costs 2 cycles: one read, then one write.

Parameters:
- AW, 16, address width of `dm_addr`, `src_addr` and `dst_addr`.
- DW, 16, data word width.
- LW, 14, width of `len`; maximum length is 8192 words.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- abort  input  1  synchronous cancel of a transfer in progress.
- src_addr  input  AW  first source word address; latched on accepted start.
- dst_addr  input  AW  first destination word address; latched on accepted start.
- len  input  LW  number of words to copy; latched on accepted start.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when a transfer completes normally.
- dm_addr  output  AW  memory address, registered.
- dm_re  output  1  memory read enable, registered.
- dm_we  output  1  memory write enable, registered.
- dm_wrt_data  output  DW  memory write data, registered.
- dm_rd_data  input  DW  memory read data; valid after the negedge that follows a cycle with `dm_re` high.

Behaviour:
- Reset:
  - One clock; rst_n is asynchronous and active-low.
  - `rst_n` low forces state IDLE and sets busy=0, done=0, dm_re=0, dm_we=0, dm_addr=0, dm_wrt_data=0, and clears all internal counters and pointers.
  - Reset mid-transfer deasserts re/we immediately, with no completion pulse.
- States: IDLE, READ, WRITE.
  - All outputs are registered and reflect the state entered at the last posedge.
- IDLE:
  - start=1 with len≠0: latch the pointers and count; next state READ with dm_re=1, dm_addr=src pointer.
  - start=1 with len=0: stay IDLE and pulse done the next cycle; no memory access occurs.
- READ → WRITE:
  - Capture dm_rd_data into dm_wrt_data.
  - Set dm_we=1, dm_re=0, dm_addr=dst pointer.
  - Increment the src pointer.
- WRITE:
  - Increment the dst pointer and decrement the remaining count.
  - If remaining was >1: go to READ with dm_re=1, dm_we=0, dm_addr=new src pointer.
  - Otherwise: go to IDLE with dm_we=0, done=1 for exactly one cycle, busy=0.
- Latency:
  - Start is accepted at edge t0.
  - Word k (from 0) is read in cycle t0+2k and written in cycle t0+2k+1.
  - done is high during the cycle after edge t0+2N, and busy is high for exactly 2N cycles.
- Invariants:
  - dm_re and dm_we are never both 1.
  - Neither dm_re nor dm_we is asserted in IDLE.
- Pointers are AW bits and wrap 0xFFFF→0x0000 (modulo).
- Overlap: strictly forward word-by-word copy, with no overlap detection. For example, dst=src+1 replicates the first word across the range.
- start while busy: ignored; the latched parameters are unchanged.
- abort=1 in READ or WRITE: the next state is IDLE with re/we=0 and no done pulse. A write already issued in the current cycle still completes at that negedge.
- abort and start together in IDLE: start wins; abort is ignored in IDLE.
- dm_wrt_data holds its last value when idle.

Optional Feature:
- Macro: DM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output `checksum` [DW-1:0], cleared to 0 on reset and on every accepted start.
  - Each captured read word is added to it (modulo 2^DW) on the READ→WRITE edge.
  - It is stable and valid while done=1 and holds until the next start.
- Undefined: no port is added and no adder logic exists; all other behaviour is identical.

Test Plan:
1. Preload mem[0x0100..0x0103]={0x1111,0x2222,0x3333,0x4444}; start with src=0x0100, dst=0x0200, len=4 -> mem[0x0200..0x0203] matches, busy high 8 cycles, single done pulse, re/we never overlap; checksum=0xAAAA when DM_COPY_CHECKSUM_EN is defined.
2. start with len=0 -> done pulses the next cycle, busy stays 0, dm_re/dm_we stay 0.
3. src=0xFFFE, dst=0x0010, len=3 -> reads 0xFFFE, 0xFFFF, 0x0000 in order, then writes 0x0010..0x0012.
4. mem[0x20]=0xBEEF; src=0x20, dst=0x21, len=3 -> mem[0x21..0x23] all 0xBEEF (forward-overlap replication).
5. start len=8, assert abort in cycle 5 -> exactly 3 words written, IDLE next cycle, no done; a second start pulse applied during the transfer is ignored.
6. Drop rst_n mid-WRITE -> dm_we falls asynchronously, all outputs read 0; a new start after release copies correctly.
